// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - funct3 codes, FSM state and access-size decode shared by the load/store unit
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {IDLE, BUS, RESP} lsu_state_t;

  typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} lsu_size_t;

  // funct3[1:0] encodes the size for both loads and stores; bit 2 only selects zero-extension
  function automatic lsu_size_t f3_size(input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   f3_size = SZ_B;
      2'b01:   f3_size = SZ_H;
      default: f3_size = SZ_W;
    endcase
  endfunction

endpackage

// File: rtl/lsu_if.sv
// rtl/lsu_if.sv - request/response and data-memory bus signals of the load/store unit
interface lsu_if;

  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        mem_err;

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata,
    input  mem_ack, mem_rdata, mem_err,
    output req_ready, rsp_valid, rsp_rdata, rsp_err,
    output mem_req, mem_we, mem_addr, mem_be, mem_wdata
  );

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata,
    output mem_ack, mem_rdata, mem_err,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err,
    input  mem_req, mem_we, mem_addr, mem_be, mem_wdata
  );

endinterface

// File: rtl/lsu_align.sv
// rtl/lsu_align.sv - byte lanes, store replication and load extraction/extension (combinational)
module lsu_align
  import lsu_pkg::*;
(
  input  lsu_size_t   i_size,
  input  logic [1:0]  i_st_off,
  input  logic [31:0] i_wdata,
  input  logic [2:0]  i_ld_funct3,
  input  logic [1:0]  i_ld_off,
  input  logic [31:0] i_rdata,
  output logic [3:0]  o_be,
  output logic [31:0] o_wdata,
  output logic [31:0] o_ldata
);

  logic [31:0] w_shift;

  always_comb begin
    o_be    = 4'b1111;
    o_wdata = i_wdata;
    case (i_size)
      SZ_B: begin
        o_be    = 4'b0001 << i_st_off;
        o_wdata = {4{i_wdata[7:0]}};
      end
      SZ_H: begin
        o_be    = 4'b0011 << i_st_off;
        o_wdata = {2{i_wdata[15:0]}};
      end
      default: begin
        o_be    = 4'b1111;
        o_wdata = i_wdata;
      end
    endcase
  end

  assign w_shift = i_rdata >> {i_ld_off, 3'b000};

  always_comb begin
    o_ldata = w_shift;
    case (i_ld_funct3)
      F3_B:    o_ldata = {{24{w_shift[7]}}, w_shift[7:0]};
      F3_H:    o_ldata = {{16{w_shift[15]}}, w_shift[15:0]};
      F3_BU:   o_ldata = {24'h000000, w_shift[7:0]};
      F3_HU:   o_ldata = {16'h0000, w_shift[15:0]};
      default: o_ldata = w_shift;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// rtl/lsu.sv - RV32I load/store unit: FSM, capture registers, response path
// Optional bus timeout counter is built when LSU_TIMEOUT_EN is defined.
module lsu
  import lsu_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
)
(
  input  logic  i_clk,
  input  logic  i_rst,
  lsu_if.slave  io_bus
);

  lsu_state_t  r_state;
  lsu_state_t  w_next;
  logic        r_we;
  logic [2:0]  r_funct3;
  logic [1:0]  r_off;
  logic        r_mem_req;
  logic        r_mem_we;
  logic [31:0] r_mem_addr;
  logic [3:0]  r_mem_be;
  logic [31:0] r_mem_wdata;
  logic        r_rsp_valid;
  logic        r_rsp_err;
  logic [31:0] r_rsp_rdata;

  logic        w_accept;
  logic        w_illegal;
  logic        w_misaligned;
  logic        w_bad;
  logic        w_term;
  logic        w_term_err;
  logic        w_timeout;
  lsu_size_t   w_size;
  logic [3:0]  w_be;
  logic [31:0] w_wdata;
  logic [31:0] w_ldata;

  assign io_bus.req_ready = (r_state == IDLE) && !i_rst;
  assign w_accept         = io_bus.req_valid && io_bus.req_ready;
  assign w_size           = f3_size(io_bus.req_funct3);

  always_comb begin
    w_misaligned = 1'b0;
    if (io_bus.req_we)
      w_illegal = io_bus.req_funct3[2] || (io_bus.req_funct3 == 3'b011);
    else
      w_illegal = (io_bus.req_funct3 == 3'b011) || (io_bus.req_funct3[2:1] == 2'b11);
    case (w_size)
      SZ_H:    w_misaligned = io_bus.req_addr[0];
      SZ_W:    w_misaligned = |io_bus.req_addr[1:0];
      default: w_misaligned = 1'b0;
    endcase
  end

  assign w_bad = w_illegal || w_misaligned;

  // Store lanes come from the live request; load extraction uses the captured funct3/offset.
  lsu_align u_align (
    .i_size      (w_size),
    .i_st_off    (io_bus.req_addr[1:0]),
    .i_wdata     (io_bus.req_wdata),
    .i_ld_funct3 (r_funct3),
    .i_ld_off    (r_off),
    .i_rdata     (io_bus.mem_rdata),
    .o_be        (w_be),
    .o_wdata     (w_wdata),
    .o_ldata     (w_ldata)
  );

`ifdef LSU_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] r_tmo_cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst || (r_state != BUS))
      r_tmo_cnt <= '0;
    else if (!io_bus.mem_ack && !io_bus.mem_err)
      r_tmo_cnt <= r_tmo_cnt + 1'b1;
  end

  // Fires in the last allowed idle BUS cycle so mem_req is high for exactly TIMEOUT_CYCLES cycles.
  assign w_timeout = (r_tmo_cnt == CW'(TIMEOUT_CYCLES - 1));
`else
  assign w_timeout = 1'b0;
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst)
      r_state <= IDLE;
    else
      r_state <= w_next;
  end

  always_comb begin
    w_next     = r_state;
    w_term     = 1'b0;
    w_term_err = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_accept)
          w_next = w_bad ? RESP : BUS;
      end
      BUS: begin
        if (io_bus.mem_err || io_bus.mem_ack || w_timeout) begin
          w_next     = RESP;
          w_term     = 1'b1;
          w_term_err = io_bus.mem_err || !io_bus.mem_ack;
        end
      end
      RESP:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_we        <= 1'b0;
      r_funct3    <= 3'b000;
      r_off       <= 2'b00;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= 32'h0;
      r_mem_be    <= 4'h0;
      r_mem_wdata <= 32'h0;
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_rsp_rdata <= 32'h0;
    end else begin
      r_rsp_valid <= 1'b0;
      if (w_accept) begin
        r_we     <= io_bus.req_we;
        r_funct3 <= io_bus.req_funct3;
        r_off    <= io_bus.req_addr[1:0];
        if (w_bad) begin
          r_rsp_valid <= 1'b1;
          r_rsp_err   <= 1'b1;
          r_rsp_rdata <= 32'h0;
        end else begin
          r_mem_req   <= 1'b1;
          r_mem_we    <= io_bus.req_we;
          r_mem_addr  <= {io_bus.req_addr[31:2], 2'b00};
          r_mem_be    <= w_be;
          r_mem_wdata <= io_bus.req_we ? w_wdata : 32'h0;
        end
      end
      if (w_term) begin
        r_mem_req   <= 1'b0;
        r_rsp_valid <= 1'b1;
        r_rsp_err   <= w_term_err;
        r_rsp_rdata <= (w_term_err || r_we) ? 32'h0 : w_ldata;
      end
    end
  end

  assign io_bus.mem_req   = r_mem_req;
  assign io_bus.mem_we    = r_mem_we;
  assign io_bus.mem_addr  = r_mem_addr;
  assign io_bus.mem_be    = r_mem_be;
  assign io_bus.mem_wdata = r_mem_wdata;
  assign io_bus.rsp_valid = r_rsp_valid;
  assign io_bus.rsp_err   = r_rsp_err;
  assign io_bus.rsp_rdata = r_rsp_rdata;

endmodule

// File: tb/tb_lsu.sv
// tb/tb_lsu.sv - directed self-checking bench for lsu; also covers the timeout when LSU_TIMEOUT_EN is defined
module tb_lsu;

  localparam int TMO = 16;
`ifdef LSU_TIMEOUT_EN
  localparam bit LONG_ERR = 1'b1;
`else
  localparam bit LONG_ERR = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  lsu_if bus();

  lsu #(.TIMEOUT_CYCLES(TMO)) dut (
    .i_clk  (clk),
    .i_rst  (rst),
    .io_bus (bus)
  );

  int n_vec = 0;
  int n_bad = 0;

  bit          chk_on = 1'b0;
  logic        e_ready, e_mreq, e_mwe, e_rsp, e_err;
  logic [31:0] e_maddr, e_mwdata, e_rdata;
  logic [3:0]  e_mbe;

  task automatic check32(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: access rules expressed as byte arithmetic
  function automatic int sz_bytes(input bit [2:0] f3);
    return 1 << f3[1:0];
  endfunction

  function automatic bit m_legal(input bit we, input bit [2:0] f3, input bit [31:0] a);
    bit code_ok;
    if (we) code_ok = (f3 inside {3'd0, 3'd1, 3'd2});
    else    code_ok = (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    if (!code_ok) return 1'b0;
    return (int'(a[1:0]) % sz_bytes(f3)) == 0;
  endfunction

  function automatic bit [3:0] m_be(input bit [2:0] f3, input bit [31:0] a);
    int n, off;
    bit [3:0] be;
    n = sz_bytes(f3); off = int'(a[1:0]); be = 4'h0;
    for (int i = 0; i < 4; i++) if (i >= off && i < off + n) be[i] = 1'b1;
    return be;
  endfunction

  function automatic bit [31:0] m_wdata(input bit [2:0] f3, input bit [31:0] wd);
    int n;
    bit [31:0] r;
    n = sz_bytes(f3);
    for (int i = 0; i < 4; i++) r[8*i +: 8] = wd[8*(i % n) +: 8];
    return r;
  endfunction

  function automatic bit [31:0] m_load(input bit [2:0] f3, input bit [31:0] a, input bit [31:0] rd);
    int n;
    bit [31:0] v, mask;
    n = sz_bytes(f3);
    v = rd >> (8 * int'(a[1:0]));
    if (n == 4) return v;
    mask = (32'd1 << (8 * n)) - 32'd1;
    v = v & mask;
    if (!f3[2] && v[8*n-1]) v = v | ~mask;
    return v;
  endfunction

  always @(negedge clk) begin
    if (chk_on) begin
      check32("req_ready", bus.req_ready, e_ready);
      check32("mem_req", bus.mem_req, e_mreq);
      check32("rsp_valid", bus.rsp_valid, e_rsp);
      if (e_mreq) begin
        check32("mem_we", bus.mem_we, e_mwe);
        check32("mem_addr", bus.mem_addr, e_maddr);
        check32("mem_be", bus.mem_be, e_mbe);
        check32("mem_wdata", bus.mem_wdata, e_mwdata);
      end
      if (e_rsp) begin
        check32("rsp_err", bus.rsp_err, e_err);
        check32("rsp_rdata", bus.rsp_rdata, e_rdata);
      end
    end
  end

  // One access; x_* are hand-computed literals that pin the model for this vector.
  task automatic run(input bit we, input bit [2:0] f3, input bit [31:0] addr, input bit [31:0] wd,
                     input bit [31:0] rd, input int wt, input bit ack, input bit err,
                     input bit x_err, input bit [3:0] x_be, input bit [31:0] x_wd, input bit [31:0] x_rd);
    bit ok, tmo, m_err;
    int nbus;
    bit [31:0] m_rd;
    ok = m_legal(we, f3, addr);
    nbus = wt + 1;
    tmo = 1'b0;
`ifdef LSU_TIMEOUT_EN
    if (nbus > TMO) begin tmo = 1'b1; nbus = TMO; end
`endif
    m_err = !ok || tmo || err;
    m_rd = (m_err || we) ? 32'h0 : m_load(f3, addr, rd);
    check32("pin_err", m_err, x_err);
    check32("pin_rdata", m_rd, x_rd);
    if (ok) begin
      check32("pin_be", m_be(f3, addr), x_be);
      check32("pin_wdata", we ? m_wdata(f3, wd) : 32'h0, x_wd);
    end

    bus.req_valid = 1'b1; bus.req_we = we; bus.req_funct3 = f3;
    bus.req_addr = addr; bus.req_wdata = wd;
    e_ready = 1'b1; e_mreq = 1'b0; e_rsp = 1'b0;
    @(posedge clk); #1;
    bus.req_valid = 1'b0; bus.req_wdata = $urandom;
    e_ready = 1'b0;
    if (!ok) begin
      e_rsp = 1'b1; e_err = 1'b1; e_rdata = 32'h0;
      @(posedge clk); #1;
      e_rsp = 1'b0; e_ready = 1'b1;
      return;
    end
    e_mreq = 1'b1; e_mwe = we; e_maddr = {addr[31:2], 2'b00};
    e_mbe = m_be(f3, addr); e_mwdata = we ? m_wdata(f3, wd) : 32'h0;
    for (int i = 0; i < nbus; i++) begin
      if (i == wt) begin
        bus.mem_ack = ack; bus.mem_err = err; bus.mem_rdata = rd;
      end else begin
        bus.mem_ack = 1'b0; bus.mem_err = 1'b0; bus.mem_rdata = $urandom;
      end
      @(posedge clk); #1;
    end
    bus.mem_ack = 1'b0; bus.mem_err = 1'b0;
    e_mreq = 1'b0; e_rsp = 1'b1; e_err = m_err; e_rdata = m_rd;
    @(posedge clk); #1;
    e_rsp = 1'b0; e_ready = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_funct3 = 3'b000;
    bus.req_addr = 32'h0; bus.req_wdata = 32'h0;
    bus.mem_ack = 1'b0; bus.mem_err = 1'b0; bus.mem_rdata = 32'h0;
    e_ready = 1'b0; e_mreq = 1'b0; e_rsp = 1'b0; e_err = 1'b0; e_mwe = 1'b0;
    e_maddr = 32'h0; e_mwdata = 32'h0; e_rdata = 32'h0; e_mbe = 4'h0;
    repeat (2) @(posedge clk);
    #1;
    chk_on = 1'b1;
    check32("rst_mem_we", bus.mem_we, 1'b0);
    check32("rst_mem_be", bus.mem_be, 4'h0);
    check32("rst_mem_addr", bus.mem_addr, 32'h0);
    check32("rst_mem_wdata", bus.mem_wdata, 32'h0);
    check32("rst_rsp_err", bus.rsp_err, 1'b0);
    check32("rst_rsp_rdata", bus.rsp_rdata, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0; e_ready = 1'b1;
    @(posedge clk); #1;

    //   we f3    addr          wdata         rdata        wt ack err  x_err x_be     x_wd          x_rd
    run(1, 3'd2, 32'h100, 32'hDEADBEEF, 32'h0,        1, 1, 0,   0, 4'b1111, 32'hDEADBEEF, 32'h0);
    run(1, 3'd0, 32'h103, 32'h000000A5, 32'h0,        0, 1, 0,   0, 4'b1000, 32'hA5A5A5A5, 32'h0);
    run(0, 3'd0, 32'h102, 32'h0,        32'h12F45678, 0, 1, 0,   0, 4'b0100, 32'h0,        32'hFFFFFFF4);
    run(0, 3'd4, 32'h102, 32'h0,        32'h12F45678, 0, 1, 0,   0, 4'b0100, 32'h0,        32'h000000F4);
    run(0, 3'd1, 32'h102, 32'h0,        32'h12F45678, 0, 1, 0,   0, 4'b1100, 32'h0,        32'h000012F4);
    run(0, 3'd2, 32'h102, 32'h0,        32'h12F45678, 0, 1, 0,   1, 4'b0000, 32'h0,        32'h0);
    run(0, 3'd3, 32'h100, 32'h0,        32'h12F45678, 0, 1, 0,   1, 4'b0000, 32'h0,        32'h0);
    run(0, 3'd2, 32'h200, 32'h0,        32'h11223344, 0, 1, 1,   1, 4'b1111, 32'h0,        32'h0);
    run(1, 3'd1, 32'h102, 32'h1234BEEF, 32'h0,        0, 1, 0,   0, 4'b1100, 32'hBEEFBEEF, 32'h0);
    run(0, 3'd5, 32'h106, 32'h0,        32'h8001FFFF, 0, 1, 0,   0, 4'b1100, 32'h0,        32'h00008001);
    run(0, 3'd1, 32'h100, 32'h0,        32'h00008001, 0, 1, 0,   0, 4'b0011, 32'h0,        32'hFFFF8001);
    run(1, 3'd4, 32'h100, 32'h1,        32'h0,        0, 1, 0,   1, 4'b0000, 32'h0,        32'h0);
    run(1, 3'd3, 32'h100, 32'h1,        32'h0,        0, 1, 0,   1, 4'b0000, 32'h0,        32'h0);
    run(1, 3'd1, 32'h101, 32'h1,        32'h0,        0, 1, 0,   1, 4'b0000, 32'h0,        32'h0);
    run(0, 3'd6, 32'h100, 32'h0,        32'h0,        0, 1, 0,   1, 4'b0000, 32'h0,        32'h0);
    run(0, 3'd0, 32'h103, 32'h0,        32'h80FFFFFF, 2, 1, 0,   0, 4'b1000, 32'h0,        32'hFFFFFF80);
    run(0, 3'd2, 32'h300, 32'h0,        32'h9999AAAA, 3, 0, 1,   1, 4'b1111, 32'h0,        32'h0);
    run(0, 3'd2, 32'h400, 32'h0,        32'hCAFEF00D, 15, 1, 0,  0, 4'b1111, 32'h0,        32'hCAFEF00D);
    run(0, 3'd2, 32'h500, 32'h0,        32'h55AA55AA, 20, 1, 0,  LONG_ERR, 4'b1111, 32'h0,
        LONG_ERR ? 32'h0 : 32'h55AA55AA);
    run(1, 3'd2, 32'h600, 32'h01020304, 32'h0,        0, 1, 0,   0, 4'b1111, 32'h01020304, 32'h0);

    // Stray termination while idle must be ignored
    bus.mem_ack = 1'b1; bus.mem_err = 1'b1; bus.mem_rdata = 32'hFFFFFFFF;
    @(posedge clk); #1;
    bus.mem_ack = 1'b0; bus.mem_err = 1'b0;
    @(posedge clk); #1;
    run(0, 3'd4, 32'h701, 32'h0, 32'h0000AB00, 0, 1, 0, 0, 4'b0010, 32'h0, 32'h000000AB);

    // Reset during BUS aborts the access without a response
    bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_funct3 = 3'd2; bus.req_addr = 32'h800;
    e_ready = 1'b1; e_mreq = 1'b0; e_rsp = 1'b0;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    e_ready = 1'b0; e_mreq = 1'b1; e_mwe = 1'b0; e_maddr = 32'h800; e_mbe = 4'hF; e_mwdata = 32'h0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; e_mreq = 1'b0; e_ready = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
    end
    run(1, 3'd0, 32'h900, 32'h0000005A, 32'h0, 0, 1, 0, 0, 4'b0001, 32'h5A5A5A5A, 32'h0);

    @(posedge clk); #1;
    chk_on = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/lsu.md
# lsu

Load/store unit for the single-issue RV32I core. It sits directly downstream of the ALU and consumes the ALU `result` as the effective address for loads and stores. It performs the single-word data-memory transaction over a req/ack bus and returns sign- or zero-extended load data, or an error, to writeback. It also generates byte lanes and store replication, and rejects misaligned or illegal accesses without touching the bus.

## Interface
- `TIMEOUT_CYCLES`, default 16: number of bus cycles allowed before an access is aborted. Used only when `LSU_TIMEOUT_EN` is defined.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `req_valid` in 1: the execute stage presents a memory op.
- `req_ready` out 1: high only in IDLE and only while `rst`=0.
- `req_we` in 1: 1 = store, 0 = load.
- `req_funct3` in 3: RV32I funct3. Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU. Stores: 000 SB, 001 SH, 010 SW.
- `req_addr` in 32: effective address (ALU result).
- `req_wdata` in 32: store data (rs2).
- `rsp_valid` out 1: one-cycle response pulse.
- `rsp_rdata` out 32: extended load data; 0 for stores and for errors.
- `rsp_err` out 1: misaligned access, illegal funct3, bus error, or timeout. Valid when `rsp_valid`=1.
- `mem_req` out 1: bus request, held until ack or error.
- `mem_we` out 1: bus write enable.
- `mem_addr` out 32: word-aligned address (`req_addr` with [1:0] forced to 00).
- `mem_be` out 4: byte enables.
- `mem_wdata` out 32: lane-replicated store data.
- `mem_ack` in 1: access complete; `mem_rdata` is valid in the same cycle.
- `mem_rdata` in 32: read data.
- `mem_err` in 1: bus error; terminates the access.

## Operation
- FSM states: IDLE, BUS, RESP.
- **IDLE**
  - Accepts a request on `req_valid && req_ready`. The request fields are captured into registers.
  - If the access is illegal or misaligned, the next state is RESP with err=1 and no bus cycle is issued.
  - Otherwise the next state is BUS.
- **Illegal and misaligned accesses**
  - Illegal: load funct3 of 011, 110 or 111; store funct3 with bit 2 set or equal to 011.
  - Misaligned: halfword access with addr[0]=1; word access with addr[1:0]≠00.
- **BUS**
  - `mem_req`=1. `mem_we`, `mem_addr`, `mem_be` and `mem_wdata` come from registers and stay stable until termination.
  - Termination on `mem_ack` or `mem_err` moves to RESP. If both are asserted in the same cycle, the error takes priority.
- **RESP**
  - `rsp_valid`=1 for exactly one cycle, then IDLE.
  - The response is not back-pressured; writeback always accepts it.
- **Byte enables** (off = addr[1:0])
  - Byte access: `4'b0001 << off`.
  - Halfword access: `4'b0011 << off`.
  - Word access: `4'b1111`.
  - Loads drive the same `mem_be` pattern as stores.
- **Store data**
  - SB: the low byte replicated ×4.
  - SH: the low halfword replicated ×2.
  - SW: passed through unchanged.
  - `mem_wdata` is 0 for loads.
- **Load extraction**
  - Compute `mem_rdata >> (8*off)`.
  - Take the low 8 or 16 bits of the shifted value.
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes through.
  - The result is registered into `rsp_rdata` on ack.
- `mem_ack` or `mem_err` asserted outside BUS is ignored.

## Timing
- Reset values:
  - State is IDLE.
  - `mem_req`, `mem_we`, `mem_be`, `mem_addr`, `mem_wdata` are 0.
  - `rsp_valid`, `rsp_err`, `rsp_rdata` are 0.
  - `req_ready` is 0 while `rst`=1.
- Legal access:
  - Accepted at edge N; `mem_req` is high from cycle N+1.
  - The earliest ack is in cycle N+1, which gives `rsp_valid` in cycle N+2.
  - `req_ready` is high again in cycle N+3.
- Rejected access: `rsp_valid`=1, `rsp_err`=1 in cycle N+1; `mem_req` is never asserted.
- Reset mid-BUS: `mem_req` is low the cycle after reset is sampled, and no response is produced for the aborted access.
- All outputs are registered except `req_ready`, which is decoded from state and `rst`.

## Configuration
- `LSU_TIMEOUT_EN` defined:
  - A counter is cleared on entry to BUS and incremented on every BUS cycle without ack or error.
  - When it reaches `TIMEOUT_CYCLES`, the access terminates: next state RESP, err=1, and `mem_req` drops in the following cycle.
  - An ack arriving in the same cycle as the timeout wins.
- `LSU_TIMEOUT_EN` undefined: no counter is built, and BUS waits indefinitely.

## Structure
- `lsu_pkg` contains:
  - funct3 localparams (`F3_B`, `F3_H`, `F3_W`, `F3_BU`, `F3_HU`);
  - `typedef enum logic [1:0] {IDLE, BUS, RESP} lsu_state_t`;
  - a function that returns the access size from funct3.
- `lsu_align` is a combinational sub-module that produces `mem_be` and `mem_wdata` from size/offset/wdata. It also produces the extracted and extended load word from rdata/offset/funct3.
- `lsu` contains the FSM, the capture registers, and the timeout counter.

## Test plan
- SW to 0x100 with wdata 0xDEADBEEF, ack after 2 BUS cycles:
  - `mem_addr`=0x100, `mem_be`=1111, `mem_we`=1, `mem_wdata`=0xDEADBEEF;
  - one `rsp_valid` pulse with err=0 and rdata=0.
- SB to 0x103 with wdata 0x000000A5: `mem_addr`=0x100, `mem_be`=1000, `mem_wdata`=0xA5A5A5A5.
- `mem_rdata`=0x12F45678, ack in the first BUS cycle:
  - LB @0x102 gives 0xFFFFFFF4;
  - LBU @0x102 gives 0x000000F4;
  - LH @0x102 gives 0x000012F4, with `mem_be`=1100;
  - the response arrives at N+2.
- LW @0x102 and load funct3=011 @0x100:
  - each gives `rsp_valid`=1, err=1 in cycle N+1 and rdata=0;
  - `mem_req` stays low throughout.
- LW @0x200 with `mem_ack`=`mem_err`=1 in the same cycle: err=1, rdata=0. Separately, assert `rst` during BUS: `mem_req`=0 the next cycle, no `rsp_valid`, and `req_ready`=1 the cycle after `rst` deasserts.
- With `LSU_TIMEOUT_EN` defined, `TIMEOUT_CYCLES`=16 and no ack: `mem_req` stays high for 16 cycles, then drops, and `rsp_err`=1. A follow-up SW completes normally.
